// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transfer controller.
// Mode 0 only: SCLK idles low, data sampled on the leading edge.
package spi_pkg;

  localparam int BYTE_W = 8;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_e;

  // First bit on the wire for a given byte and bit order.
  function automatic logic pick_bit(input logic [BYTE_W-1:0] b, input logic lsb_first);
    return lsb_first ? b[0] : b[BYTE_W-1];
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles while enabled.
// Counter is held at zero whenever disabled, so each enable restarts the period.
module spi_sclk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CNT_LAST);
    cnt_d = (en && !tick) ? cnt_q + CW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-byte full-duplex SPI master: fixed 17*CLK_DIV-cycle frame plus CS gap.
// START is taken in IDLE or on the edge that ends the previous frame; ignored otherwise.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int   CLK_DIV   = 2,
  parameter int   CS_GAP    = 2,
  parameter logic LSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic [BYTE_W-1:0] DATA_IN,
  output logic [BYTE_W-1:0] DATA_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS_N
);

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

  spi_state_e        state_q, state_d;
  logic [BYTE_W-1:0] tx_q, tx_d;
  logic [BYTE_W-1:0] rx_q, rx_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              bit_last_q, bit_last_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic div_en;
  logic tick;
  logic sample_edge;
  logic shift_edge;
  logic frame_end;
  logic accept;

  assign div_en = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);

  spi_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_div (
    .clk (CLK),
    .clr (CLR),
    .en  (div_en),
    .tick(tick)
  );

  // SETUP's tick is always the first leading edge; XFER alternates leading/trailing.
  assign sample_edge = tick && ((state_q == SETUP) || (state_q == XFER))
                       && (sclk_q == (SPI_CPOL ^ SPI_CPHA));
  assign shift_edge  = tick && (state_q == XFER) && (sclk_q != (SPI_CPOL ^ SPI_CPHA));

  assign frame_end = ((state_q == HOLD) && tick && (CS_GAP == 0))
                     || ((state_q == GAP) && (gap_cnt_q == GAP_LAST));
  assign accept    = START && ((state_q == IDLE) || frame_end);

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    bit_cnt_d  = bit_cnt_q;
    bit_last_d = bit_last_q;
    gap_cnt_d  = gap_cnt_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE:  ;
      SETUP: if (sample_edge) state_d = XFER;
      XFER:  if (shift_edge && bit_last_q) state_d = HOLD;
      HOLD: begin
        if (tick) begin
          cs_n_d     = 1'b1;
          data_out_d = rx_q;
          done_d     = 1'b1;
          if (CS_GAP != 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end
      end
      GAP:   if (gap_cnt_q != GAP_LAST) gap_cnt_d = gap_cnt_q + GW'(1);
      default: state_d = IDLE;
    endcase

    if (sample_edge) begin
      sclk_d = ~sclk_q;
      rx_d   = LSB_FIRST ? {MISO, rx_q[BYTE_W-1:1]} : {rx_q[BYTE_W-2:0], MISO};
    end

    // The final trailing edge leaves MOSI on bit 7 and the counter at 7 (no wrap).
    if (shift_edge) begin
      sclk_d = ~sclk_q;
      if (!bit_last_q) begin
        tx_d       = LSB_FIRST ? (tx_q >> 1) : (tx_q << 1);
        mosi_d     = pick_bit(tx_d, LSB_FIRST);
        bit_cnt_d  = bit_cnt_q + 3'd1;
        bit_last_d = (bit_cnt_q == 3'd6);
      end
    end

    if (frame_end) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      mosi_d  = 1'b0;
    end

    if (accept) begin
      state_d    = SETUP;
      tx_d       = DATA_IN;
      mosi_d     = pick_bit(DATA_IN, LSB_FIRST);
      cs_n_d     = 1'b0;
      busy_d     = 1'b1;
      sclk_d     = SPI_CPOL;
      bit_cnt_d  = 3'd0;
      bit_last_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      bit_cnt_q  <= 3'd0;
      bit_last_q <= 1'b0;
      gap_cnt_q  <= '0;
      sclk_q     <= SPI_CPOL;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_last_q <= bit_last_d;
      gap_cnt_q  <= gap_cnt_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign DATA_OUT = data_out_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign CS_N     = cs_n_q;

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Transfer controller that sequences one 8-bit full-duplex SPI exchange: asserts chip select, generates SCLK from the system clock, shifts transmit data out on MOSI, samples MISO into a receive register and reports completion. It sits between the bus-side logic, which issues a byte plus START, and the serial pins. It replaces ad-hoc TE/RE/WRITE/READ sequencing with a single synchronous state machine and a fixed, cycle-exact frame.

## Interface
- CLK_DIV, 2: SCLK half-period in CLK cycles (H); legal ≥1.
- CS_GAP, 2: minimum CLK cycles CS_N stays high between frames; legal ≥0.
- LSB_FIRST, 1: 1 = bit 0 shifted first; 0 = bit 7 first.
- CLK  in  1  system clock; all logic on rising edge.
- CLR  in  1  synchronous, active-high reset.
- START  in  1  request a transfer; honoured only when BUSY=0.
- DATA_IN  in  8  transmit byte; captured on the accepting edge.
- DATA_OUT  out  8  last received byte; updated only when DONE asserts.
- BUSY  out  1  high from the accepting edge until the end of the gap.
- DONE  out  1  one-cycle pulse, frame complete.
- SCLK  out  1  serial clock, idle low (mode 0).
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- CS_N  out  1  chip select, active low.

## Operation
- States: IDLE, SETUP, XFER, HOLD, GAP.
- IDLE: CS_N=1, SCLK=0, BUSY=0. START=1 -> load the TX shift register from DATA_IN, set CS_N=0, drive the first bit on MOSI, clear the bit counter and go to SETUP.
- SETUP: wait H cycles, then go to XFER with SCLK rising.
- XFER: SCLK toggles every H cycles. On each 0->1 edge, sample MISO into the RX shift register in the same bit order as transmit. On each 1->0 edge, advance MOSI to the next bit, except after bit 7. After the 8th falling edge, go to HOLD.
- HOLD: wait H cycles, then set CS_N=1, load DATA_OUT from the RX register, pulse DONE, and go to GAP. If CS_GAP=0, go directly to IDLE.
- GAP: count CS_GAP cycles, then go to IDLE and drop BUSY.
- START is ignored while BUSY=1; there is no queueing. START held high in IDLE starts the next frame immediately.
- MOSI holds the last bit through HOLD. It returns to 0 in IDLE.
- The divider counter is wide enough for CLK_DIV-1. The bit counter is 3 bits plus a terminal flag; there is no wrap into a 9th bit.

## Timing
Let START be accepted at edge k, with H=CLK_DIV.
- After edge k: BUSY=1, CS_N=0, MOSI=first bit, SCLK=0.
- Bit i (0..7): SCLK rises at edge k+H+2Hi, when MISO is sampled. SCLK falls at edge k+2H+2Hi.
- CS_N rises at edge k+17H. DATA_OUT is valid and DONE=1 in the cycle after edge k+17H.
- BUSY falls at edge k+17H+CS_GAP. The earliest next accept is at that same edge.
- Reset values (CLR=1 at any edge, all outputs on the next cycle): CS_N=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, DATA_OUT=0x00, state IDLE.
- CLR during a frame aborts it: no DONE, and DATA_OUT keeps 0x00 from reset.
- CLR and START asserted on the same edge: CLR wins and the START is dropped.

## Structure
- Package spi_pkg holds:
  - the state enum (IDLE, SETUP, XFER, HOLD, GAP);
  - the byte width constant (8);
  - the SPI mode constants (CPOL=0, CPHA=0).
- One sub-module, spi_sclk_div: a half-period tick generator. It is enabled by the FSM, restarts on enable, and emits a one-cycle tick every CLK_DIV cycles. Shift registers and the FSM stay in the top level.

## Test plan
- Reset: CLR high for 2 cycles mid-IDLE -> CS_N=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, DATA_OUT=0x00.
- Loopback: H=2, CS_GAP=2, MISO tied to MOSI, DATA_IN=0xA5, START at edge 0 ->
  - MOSI sequence 1,0,1,0,0,1,0,1;
  - SCLK rises at edges 2,6,…,30;
  - CS_N high at edge 34 and DONE pulse in the following cycle;
  - DATA_OUT=0xA5;
  - BUSY low at edge 36.
- Independent MISO: slave model drives 0x3C (LSB first) while sending 0xFF -> DATA_OUT=0x3C and exactly 8 SCLK rising edges.
- Busy rejection: START pulsed at edges 5 and 20 of a frame -> no effect. With START held high continuously -> second frame accepted at edge 36 and CS_N low again after it.
- Abort: CLR at edge 12 of a frame -> CS_N=1 and SCLK=0 the next cycle, no DONE, DATA_OUT=0x00. A new START at edge 14 -> full frame completes normally.
- Parameter corners: CLK_DIV=1, CS_GAP=0, LSB_FIRST=0, DATA_IN=0x80 -> MOSI first bit 1, DONE in the cycle after edge 17, BUSY low at edge 17.
